// File: rtl/keymap_pkg.sv
// Shared types and constants for the PS/2 key-mapping controller.
// Holds the prefix FSM encoding, scancode prefixes and default key codes.
package keymap_pkg;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} pfx_state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam logic [15:0] KC_SPACE = 16'h0029;
  localparam logic [15:0] KC_RIGHT = 16'hE074;
  localparam logic [15:0] KC_LEFT  = 16'hE06B;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_SPACE = 2;

  // Extended codes carry E0 in the upper byte, plain codes carry 00.
  function automatic logic [15:0] make_code(input logic ext, input logic [7:0] b);
    return {(ext ? PFX_EXT : 8'h00), b};
  endfunction

endpackage

// File: rtl/keymap_if.sv
// Byte-event input and key-state outputs of the key-mapping controller.
// master = PS/2 receiver / consumer side, slave = the controller.
interface keymap_if #(
  parameter int NUM_KEYS = 3,
  parameter int CHARGE_W = 6
);
  logic [15:0]         keycode;
  logic                oflag;
  logic [NUM_KEYS-1:0] key_down;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [CHARGE_W-1:0] charge_value;
  logic                charge_done;
  logic                charging;

  modport master (
    output keycode, oflag,
    input  key_down, key_press, key_release, charge_value, charge_done, charging
  );

  modport slave (
    input  keycode, oflag,
    output key_down, key_press, key_release, charge_value, charge_done, charging
  );
endinterface

// File: rtl/keymap_charge_timer.sv
// Hold-duration timer: a prescaler producing ticks every TICK_DIV cycles and a
// saturating tick counter, started by a press pulse and latched by a release pulse.
module charge_timer #(
  parameter int TICK_DIV   = 100000,
  parameter int CHARGE_MAX = 63,
  parameter int CHARGE_W   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  output logic                charging,
  output logic [CHARGE_W-1:0] charge_value,
  output logic                charge_done
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]       presc_reg;
  logic [CHARGE_W-1:0] count_reg;
  logic [CHARGE_W-1:0] count_next;
  logic [CHARGE_W-1:0] value_reg;
  logic                charging_reg;
  logic                done_reg;
  logic                tick;

  assign tick = charging_reg && (presc_reg == PW'(TICK_DIV - 1));

  // The release may coincide with a tick, so latch the post-tick count.
  always_comb begin
    count_next = count_reg;
    if (tick && (count_reg != CHARGE_W'(CHARGE_MAX)))
      count_next = count_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg    <= '0;
      count_reg    <= '0;
      value_reg    <= '0;
      charging_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= stop;
      if (start) begin
        presc_reg    <= '0;
        count_reg    <= '0;
        charging_reg <= 1'b1;
      end else if (stop) begin
        value_reg    <= count_next;
        count_reg    <= count_next;
        charging_reg <= 1'b0;
      end else if (charging_reg) begin
        presc_reg <= tick ? '0 : presc_reg + 1'b1;
        count_reg <= count_next;
      end
    end
  end

  assign charging     = charging_reg;
  assign charge_value = value_reg;
  assign charge_done  = done_reg;
endmodule

// File: rtl/keymap_ctl.sv
// PS/2 key-mapping controller: E0/F0 prefix decoding, programmable key table
// with held/press/release outputs, and a hold-duration timer on one key.
module keymap_ctl
  import keymap_pkg::*;
#(
  parameter int                     NUM_KEYS   = 3,
  parameter logic [16*NUM_KEYS-1:0] KEY_CODES  = {KC_SPACE, KC_RIGHT, KC_LEFT},
  parameter int                     CHARGE_KEY = KEY_LEFT,
  parameter int                     TICK_DIV   = 100000,
  parameter int                     CHARGE_MAX = 63,
  parameter int                     CHARGE_W   = 6
) (
  input logic     clk,
  input logic     rst_n,
  keymap_if.slave bus
);
  logic                oflag_q;
  logic                ev;
  logic [7:0]          new_byte;
  pfx_state_t          state_reg, state_next;
  logic                resolve, ext_flag, brk_flag, is_break;
  logic [15:0]         code;
  logic [NUM_KEYS-1:0] down_reg, press_reg, release_reg;
  logic [NUM_KEYS-1:0] press_next, release_next;

  // oflag may stay high for many cycles; only its rising edge is an event.
  assign ev       = bus.oflag & ~oflag_q;
  assign new_byte = bus.keycode[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oflag_q   <= 1'b0;
      state_reg <= IDLE;
    end else begin
      oflag_q   <= bus.oflag;
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    resolve    = 1'b0;
    ext_flag   = 1'b0;
    brk_flag   = 1'b0;
    if (ev) begin
      case (state_reg)
        IDLE: begin
          if (new_byte == PFX_EXT)      state_next = EXT;
          else if (new_byte == PFX_BRK) state_next = BRK;
          else                          resolve = 1'b1;
        end
        EXT: begin
          if (new_byte == PFX_BRK)      state_next = EXT_BRK;
          else if (new_byte == PFX_EXT) state_next = EXT;
          else begin
            resolve    = 1'b1;
            ext_flag   = 1'b1;
            state_next = IDLE;
          end
        end
        BRK: begin
          if (new_byte == PFX_EXT)      state_next = EXT_BRK;
          else if (new_byte == PFX_BRK) state_next = BRK;
          else begin
            resolve    = 1'b1;
            brk_flag   = 1'b1;
            state_next = IDLE;
          end
        end
        EXT_BRK: begin
          if ((new_byte != PFX_EXT) && (new_byte != PFX_BRK)) begin
            resolve    = 1'b1;
            ext_flag   = 1'b1;
            brk_flag   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A receiver that already paired F0 with the key byte reports it in the upper byte.
  assign is_break = brk_flag | (bus.keycode[15:8] == PFX_BRK);
  assign code     = make_code(ext_flag, new_byte);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic match;
      assign match            = resolve && (code == KEY_CODES[gi*16 +: 16]);
      assign press_next[gi]   = match & ~is_break & ~down_reg[gi];
      assign release_next[gi] = match &  is_break &  down_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      down_reg    <= '0;
      press_reg   <= '0;
      release_reg <= '0;
    end else begin
      down_reg    <= (down_reg | press_next) & ~release_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  assign bus.key_down    = down_reg;
  assign bus.key_press   = press_reg;
  assign bus.key_release = release_reg;

  charge_timer #(
    .TICK_DIV  (TICK_DIV),
    .CHARGE_MAX(CHARGE_MAX),
    .CHARGE_W  (CHARGE_W)
  ) u_charge (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (press_next[CHARGE_KEY]),
    .stop        (release_next[CHARGE_KEY]),
    .charging    (bus.charging),
    .charge_value(bus.charge_value),
    .charge_done (bus.charge_done)
  );
endmodule

// File: tb/tb_keymap_ctl.sv
// Self-checking bench for keymap_ctl: directed scenarios plus random byte
// streams compared against a flag-based reference model of the key rules.
module tb_keymap_ctl;
  import keymap_pkg::*;

  localparam int NK   = 3;
  localparam int CW   = 6;
  localparam int TDIV = 10;
  localparam int CMAX = 63;
  localparam int CKEY = 2;

  logic clk;
  logic rst_n;
  keymap_if #(.NUM_KEYS(NK), .CHARGE_W(CW)) bus ();

  keymap_ctl #(
    .NUM_KEYS  (NK),
    .KEY_CODES ({KC_SPACE, KC_RIGHT, KC_LEFT}),
    .CHARGE_KEY(CKEY),
    .TICK_DIV  (TDIV),
    .CHARGE_MAX(CMAX),
    .CHARGE_W  (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int act_press[NK];
  int act_rel[NK];
  int act_done = 0;

  // reference model state
  logic [15:0] codes[NK] = '{KC_LEFT, KC_RIGHT, KC_SPACE};
  bit exp_down[NK];
  int exp_press[NK];
  int exp_rel[NK];
  int exp_done = 0;
  int exp_value = 0;
  bit exp_charging = 0;
  int press_edge = 0;
  bit m_ext = 0;
  bit m_brk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < NK; i++) begin
      act_press[i] <= act_press[i] + int'(bus.key_press[i] === 1'b1);
      act_rel[i]   <= act_rel[i] + int'(bus.key_release[i] === 1'b1);
    end
    act_done <= act_done + int'(bus.charge_done === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    #1;
    for (int i = 0; i < NK; i++) begin
      chk($sformatf("%s key_down[%0d]", tag, i), 32'(bus.key_down[i]), int'(exp_down[i]));
      chk($sformatf("%s press_cnt[%0d]", tag, i), act_press[i], exp_press[i]);
      chk($sformatf("%s release_cnt[%0d]", tag, i), act_rel[i], exp_rel[i]);
    end
    chk({tag, " charge_done_cnt"}, act_done, exp_done);
    chk({tag, " charge_value"}, 32'(bus.charge_value), exp_value);
    chk({tag, " charging"}, 32'(bus.charging), int'(exp_charging));
    $display("step %-12s kc=%h down=%b val=%0d chg=%b", tag, bus.keycode, bus.key_down,
             bus.charge_value, bus.charging);
  endtask

  // Prefixes accumulate as flags until a non-prefix byte resolves them.
  task automatic model_event(input logic [15:0] kc, input int ev_edge);
    logic [7:0]  b;
    logic [15:0] code;
    bit          brk;
    int          ticks;
    b = kc[7:0];
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      code = {(m_ext ? 8'hE0 : 8'h00), b};
      brk  = m_brk || (kc[15:8] == 8'hF0);
      m_ext = 0;
      m_brk = 0;
      for (int i = 0; i < NK; i++) begin
        if (code == codes[i]) begin
          if (!brk && !exp_down[i]) begin
            exp_down[i] = 1;
            exp_press[i]++;
            if (i == CKEY) begin
              press_edge   = ev_edge;
              exp_charging = 1;
            end
          end else if (brk && exp_down[i]) begin
            exp_down[i] = 0;
            exp_rel[i]++;
            if (i == CKEY) begin
              ticks        = (ev_edge - press_edge) / TDIV;
              exp_value    = (ticks > CMAX) ? CMAX : ticks;
              exp_done++;
              exp_charging = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NK; i++) exp_down[i] = 0;
    exp_value    = 0;
    exp_charging = 0;
    m_ext        = 0;
    m_brk        = 0;
  endtask

  // oflag high for 'hold' cycles, then low for 'gap' cycles (hold, gap >= 1).
  task automatic send(input logic [15:0] kc, input int hold, input int gap);
    @(negedge clk);
    bus.keycode = kc;
    bus.oflag   = 1'b1;
    model_event(kc, cyc + 1);
    repeat (hold) @(negedge clk);
    bus.oflag = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  logic [15:0] pool[10] = '{16'h0029, 16'hF029, 16'h00E0, 16'h00F0, 16'h0074,
                            16'h006B, 16'h001C, 16'hF074, 16'hE029, 16'h00F0};

  initial begin
    rst_n = 1'b0;
    bus.keycode = 16'h0000;
    bus.oflag   = 1'b0;
    for (int i = 0; i < NK; i++) begin
      act_press[i] = 0;
      act_rel[i]   = 0;
      exp_down[i]  = 0;
      exp_press[i] = 0;
      exp_rel[i]   = 0;
    end
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // long-held oflag yields one event each
    send(16'h0029, 500, 2);
    check_all("make");
    chk("make press_cnt[2] directed", act_press[2], 1);
    send(16'hF029, 500, 2);
    check_all("break");
    chk("break release_cnt[2] directed", act_rel[2], 1);

    // extended make then extended break of right arrow
    send(16'h00E0, 1, 1);
    send(16'h0074, 1, 1);
    check_all("ext_make");
    chk("ext_make key_down[1] directed", 32'(bus.key_down[1]), 1);
    send(16'h00E0, 1, 1);
    send(16'h00F0, 1, 1);
    send(16'h0074, 1, 1);
    check_all("ext_break");
    send(16'h0074, 3, 2);
    check_all("bare74");

    // typematic repeats and unmapped code
    repeat (3) send(16'h0029, 4, 2);
    check_all("typematic");
    send(16'h001C, 4, 2);
    check_all("unmapped");
    send(16'hF029, 4, 2);
    check_all("space_up");

    // release edge lands 55, 60 and 1000 edges after the press edge
    send(16'h0029, 10, 44);
    send(16'hF029, 5, 3);
    check_all("charge55");
    chk("charge55 value directed", 32'(bus.charge_value), 5);
    send(16'h0029, 10, 49);
    send(16'hF029, 5, 3);
    check_all("charge60");
    chk("charge60 value directed", 32'(bus.charge_value), 6);
    send(16'h0029, 10, 989);
    send(16'hF029, 5, 3);
    check_all("charge1000");
    chk("charge1000 value directed", 32'(bus.charge_value), CMAX);

    // random byte streams
    for (int n = 0; n < 300; n++) begin
      send(pool[$urandom_range(0, 9)], $urandom_range(1, 20), $urandom_range(1, 5));
      check_all($sformatf("rnd%0d", n));
    end

    // flush any pending prefix, then hold all three keys
    send(16'h0011, 1, 1);
    send(16'h0029, 2, 1);
    send(16'h00E0, 1, 1);
    send(16'h0074, 1, 1);
    send(16'h00E0, 1, 1);
    send(16'h006B, 1, 1);
    check_all("all_down");
    chk("all_down vector", 32'(bus.key_down), 7);

    // asynchronous reset between clock edges
    repeat (17) @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst key_down", 32'(bus.key_down), 0);
    chk("async_rst key_press", 32'(bus.key_press), 0);
    chk("async_rst key_release", 32'(bus.key_release), 0);
    chk("async_rst charge_value", 32'(bus.charge_value), 0);
    chk("async_rst charge_done", 32'(bus.charge_done), 0);
    chk("async_rst charging", 32'(bus.charging), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h0029, 3, 2);
    check_all("post_reset");
    send(16'hF029, 3, 2);
    check_all("post_rst_brk");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
